// File: rtl/skywave_pkg.sv
// Shared types for the SoC reset sequencer: FSM states, reset cause codes and
// the elaboration-time sizing helper.
package skywave_pkg;

  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STRETCH   = 3'd2,
    BUS_UP    = 3'd3,
    RUN       = 3'd4
  } rst_state_t;

  // 2'b11 is reserved and never produced
  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_PLL = 2'b01,
    CAUSE_SW  = 2'b10
  } rst_cause_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Reset sequencer boundary: PLL/software request in, ordered resets and cause out.
interface rst_seq_if;

  logic                             pll_locked_i;
  logic                             sw_reset_req_i;
  logic                             bus_reset_o;
  logic                             core_reset_o;
  logic                             ready_o;
  logic [skywave_pkg::CAUSE_W-1:0]  reset_cause_o;

  modport master (
    input  pll_locked_i,
    input  sw_reset_req_i,
    output bus_reset_o,
    output core_reset_o,
    output ready_o,
    output reset_cause_o
  );

  modport slave (
    output pll_locked_i,
    output sw_reset_req_i,
    input  bus_reset_o,
    input  core_reset_o,
    input  ready_o,
    input  reset_cause_o
  );

endinterface

// File: rtl/sync_ff.sv
// Generic two-flop synchroniser; reset clears both stages to 0.
module sync_ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds, waits for a stable PLL lock, releases the bus fabric,
// then the cores after a gap; records the cause of the most recent reset.
module rst_seq
  import skywave_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned LOCK_STRETCH = 8,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic      clk_i,
  input  logic      reset_i,
  rst_seq_if.master rif
);

  localparam int unsigned MAX_P = max3(HOLD_CYCLES, LOCK_STRETCH, GAP_CYCLES);
  localparam int unsigned CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(LOCK_STRETCH - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);

  if (HOLD_CYCLES < 1 || LOCK_STRETCH < 1 || GAP_CYCLES < 1) begin : g_param_check
    $error("rst_seq: HOLD_CYCLES, LOCK_STRETCH and GAP_CYCLES must all be >= 1");
  end

  rst_state_t       state_q, state_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  rst_cause_t       cause_q, cause_nxt;
  logic             bus_rst_q, core_rst_q, ready_q;
  logic             bus_rst_nxt, core_rst_nxt, ready_nxt;
  logic             locked_s;

  sync_ff #(.WIDTH(1)) u_lock_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (rif.pll_locked_i),
    .q_o     (locked_s)
  );

  // Next state, counter and cause; outputs decode the next state so they land in flops
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    cause_nxt = cause_q;

    unique case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          if (!rif.sw_reset_req_i) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STRETCH;
          cnt_nxt   = '0;
        end
      end
      STRETCH: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt_q == STRETCH_LAST) begin
          state_nxt = BUS_UP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      BUS_UP, RUN: begin
        // Lock loss outranks a simultaneous software request
        if (!locked_s) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          cause_nxt = CAUSE_PLL;
        end else if (rif.sw_reset_req_i) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          cause_nxt = CAUSE_SW;
        end else if (state_q == BUS_UP) begin
          if (cnt_q == GAP_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
    endcase

    bus_rst_nxt  = !(state_nxt == BUS_UP || state_nxt == RUN);
    core_rst_nxt = (state_nxt != RUN);
    ready_nxt    = (state_nxt == RUN);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      cause_q    <= CAUSE_POR;
      bus_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      cause_q    <= cause_nxt;
      bus_rst_q  <= bus_rst_nxt;
      core_rst_q <= core_rst_nxt;
      ready_q    <= ready_nxt;
    end
  end

  assign rif.bus_reset_o   = bus_rst_q;
  assign rif.core_reset_o  = core_rst_q;
  assign rif.ready_o       = ready_q;
  assign rif.reset_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed timeline steps plus a randomized tail, all checked
// every cycle against a timestamp-style reference model of the sequencing rules.
module tb_rst_seq;

  localparam int unsigned P_HOLD = 4;
  localparam int unsigned P_STR  = 8;
  localparam int unsigned P_GAP  = 2;

  logic clk     = 1'b0;
  logic reset_i = 1'b0;

  always #5 clk = ~clk;

  rst_seq_if rif();

  rst_seq #(
    .HOLD_CYCLES  (P_HOLD),
    .LOCK_STRETCH (P_STR),
    .GAP_CYCLES   (P_GAP)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .rif     (rif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lock delayed two samples, hold progress, length of the
  // current run of lock samples, and time since the bus was released.
  bit         m_pd1 = 1'b0, m_pd2 = 1'b0;
  int         m_hold = 0, m_lock = 0, m_up = 0;
  bit         m_rel = 1'b0;
  logic [1:0] m_cause = 2'b00;

  always @(posedge clk) begin : model
    bit ls;
    ls = m_pd2;
    if (!reset_i) begin
      m_pd1 = 1'b0; m_pd2 = 1'b0;
      m_hold = 0; m_lock = 0; m_up = 0; m_rel = 1'b0;
      m_cause = 2'b00;
    end else begin
      m_pd2 = m_pd1;
      m_pd1 = rif.pll_locked_i;
      if (m_rel) begin
        if (!ls || rif.sw_reset_req_i) begin
          m_cause = !ls ? 2'b01 : 2'b10;
          m_rel = 1'b0; m_hold = 0; m_lock = 0; m_up = 0;
        end else if (m_up < int'(P_GAP)) begin
          m_up++;
        end
      end else if (m_hold < int'(P_HOLD)) begin
        if (!(m_hold == int'(P_HOLD) - 1 && rif.sw_reset_req_i)) m_hold++;
      end else begin
        m_lock = ls ? m_lock + 1 : 0;
        if (m_lock == int'(P_STR) + 1) begin
          m_rel = 1'b1;
          m_up  = 0;
        end
      end
    end
  end

  string phase = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_model();
    logic run_ok;
    run_ok = m_rel && (m_up >= int'(P_GAP));
    chk({phase, " bus"},   32'(rif.bus_reset_o),   32'(!m_rel));
    chk({phase, " core"},  32'(rif.core_reset_o),  32'(!run_ok));
    chk({phase, " ready"}, 32'(rif.ready_o),       32'(run_ok));
    chk({phase, " cause"}, 32'(rif.reset_cause_o), 32'(m_cause));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk_model();
  endtask

  // Cycles (counting the first edge as 1) until ready_o rises, bounded
  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      step();
      n++;
      if (rif.ready_o === 1'b1) break;
    end
  endtask

  task automatic por_timeline(input string tag);
    for (int n = 1; n <= 16; n++) begin
      step();
      chk({tag, " bus@edge"},   32'(rif.bus_reset_o),  32'(n < 13));
      chk({tag, " core@edge"},  32'(rif.core_reset_o), 32'(n < 15));
      chk({tag, " ready@edge"}, 32'(rif.ready_o),      32'(n >= 15));
    end
    chk({tag, " cause"}, 32'(rif.reset_cause_o), 32'(2'b00));
  endtask

  initial begin
    int n;
    rif.pll_locked_i   = 1'b1;
    rif.sw_reset_req_i = 1'b0;

    // Reset held low
    phase = "reset";
    @(negedge clk);
    repeat (3) step();
    chk("reset bus",   32'(rif.bus_reset_o),   32'(1));
    chk("reset core",  32'(rif.core_reset_o),  32'(1));
    chk("reset ready", 32'(rif.ready_o),       32'(0));
    chk("reset cause", 32'(rif.reset_cause_o), 32'(0));

    // Power-on timeline
    phase = "por";
    reset_i = 1'b1;
    por_timeline("por");

    // Software reset held for 10 cycles in RUN
    phase = "sw";
    rif.sw_reset_req_i = 1'b1;
    step();
    chk("sw bus",   32'(rif.bus_reset_o),   32'(1));
    chk("sw core",  32'(rif.core_reset_o),  32'(1));
    chk("sw ready", 32'(rif.ready_o),       32'(0));
    chk("sw cause", 32'(rif.reset_cause_o), 32'(2'b10));
    repeat (9) step();
    chk("sw held core", 32'(rif.core_reset_o), 32'(1));
    rif.sw_reset_req_i = 1'b0;
    wait_ready(40, n);
    chk("sw drop-to-ready", 32'(n), 32'(12));
    chk("sw cause in run",  32'(rif.reset_cause_o), 32'(2'b10));

    // PLL glitch during STRETCH restarts the full stretch
    phase = "glitch";
    rif.sw_reset_req_i = 1'b1;
    step();
    rif.sw_reset_req_i = 1'b0;
    repeat (6) step();
    rif.pll_locked_i = 1'b0;
    repeat (3) step();
    rif.pll_locked_i = 1'b1;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (rif.bus_reset_o === 1'b0) break;
    end
    chk("glitch relock-to-bus", 32'(n), 32'(11));
    wait_ready(10, n);
    chk("glitch bus-to-ready", 32'(n), 32'(2));

    // PLL loss in RUN, then an indefinite wait for relock
    phase = "pll_loss";
    rif.pll_locked_i = 1'b0;
    n = 0;
    while (n < 10) begin
      step();
      n++;
      if (rif.bus_reset_o === 1'b1) break;
    end
    chk("pll_loss latency", 32'(n), 32'(3));
    chk("pll_loss cause",   32'(rif.reset_cause_o), 32'(2'b01));
    repeat (40) step();
    chk("pll_loss still held", 32'(rif.bus_reset_o), 32'(1));
    rif.pll_locked_i = 1'b1;
    wait_ready(40, n);
    chk("pll_loss relock-to-ready", 32'(n), 32'(13));

    // Software request on the same edge the synchronised lock falls
    phase = "both";
    rif.pll_locked_i = 1'b0;
    repeat (2) step();
    rif.sw_reset_req_i = 1'b1;
    step();
    chk("both bus",   32'(rif.bus_reset_o),   32'(1));
    chk("both cause", 32'(rif.reset_cause_o), 32'(2'b01));
    rif.sw_reset_req_i = 1'b0;
    rif.pll_locked_i   = 1'b1;
    wait_ready(60, n);
    chk("both recovered", 32'(rif.ready_o), 32'(1));

    // reset_i pulse during BUS_UP after a software-caused reset
    phase = "rst_busup";
    rif.sw_reset_req_i = 1'b1;
    step();
    rif.sw_reset_req_i = 1'b0;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (rif.bus_reset_o === 1'b0) break;
    end
    chk("rst_busup in bus_up core",  32'(rif.core_reset_o),  32'(1));
    chk("rst_busup prior cause",     32'(rif.reset_cause_o), 32'(2'b10));
    reset_i = 1'b0;
    step();
    chk("rst_busup bus",   32'(rif.bus_reset_o),   32'(1));
    chk("rst_busup core",  32'(rif.core_reset_o),  32'(1));
    chk("rst_busup cause", 32'(rif.reset_cause_o), 32'(2'b00));
    reset_i = 1'b1;
    phase = "re_por";
    por_timeline("re_por");

    // Randomized tail: lock drops, software requests and rare resets
    phase = "random";
    for (int i = 0; i < 600; i++) begin
      if (rif.pll_locked_i)
        rif.pll_locked_i = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      else
        rif.pll_locked_i = ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0;
      if (rif.sw_reset_req_i)
        rif.sw_reset_req_i = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
      else
        rif.sw_reset_req_i = ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0;
      reset_i = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset sequencer that sits directly upstream of every reset consumer in the SoC top (bus fabric, PE cores, operator panel interface).
- Inputs: PLL lock indication and the processor's software reset request.
- Produces ordered, registered, active-high resets: bus fabric leaves reset first, processor core follows after a programmable gap.
- Records why the last reset happened, for software and the operator panel.

Parameters:
- HOLD_CYCLES, 4: minimum cycles both resets stay asserted after any reset event; must be ≥1.
- LOCK_STRETCH, 8: cycles PLL lock must stay continuously high before the bus is released; must be ≥1.
- GAP_CYCLES, 2: cycles between bus release and core release; must be ≥1.

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  synchronous, active-low reset
- pll_locked_i  input  1  PLL lock, asynchronous to clk_i
- sw_reset_req_i  input  1  software reset request from PE0, level, clk_i domain
- bus_reset_o  output  1  active-high reset to bus fabric
- core_reset_o  output  1  active-high reset to processor cores and OPI
- ready_o  output  1  high only in RUN
- reset_cause_o  output  2  00 POR, 01 PLL_LOSS, 10 SW, 11 reserved (never driven)

Behaviour:
- One clock (clk_i). Reset is synchronous, active-low, on reset_i.
- pll_locked_i passes through a 2-flop synchroniser (locked_s).
  - Sync flops reset to 0.
  - Latency is 2 edges.
- FSM states: HOLD, WAIT_LOCK, STRETCH, BUS_UP, RUN.
- Outputs are a Moore decode of the registered state:
  - HOLD, WAIT_LOCK, STRETCH: bus_reset_o=1, core_reset_o=1.
  - BUS_UP: bus_reset_o=0, core_reset_o=1.
  - RUN: bus_reset_o=0, core_reset_o=0, ready_o=1.
- While reset_i=0: state=HOLD, cnt=0, cause=POR, bus_reset_o=1, core_reset_o=1, ready_o=0. Applies from any state, including mid-sequence.
- Counting rule: cnt clears on entry to every state. A counting state with parameter P increments each cycle and exits on the edge where cnt==P-1, so it occupies exactly P cycles.
- HOLD:
  - Counts HOLD_CYCLES.
  - At terminal count, moves to WAIT_LOCK only if sw_reset_req_i=0; otherwise cnt saturates at P-1 and the state stays in HOLD until the request drops.
- WAIT_LOCK: moves to STRETCH on the first edge with locked_s=1. No timeout.
- STRETCH:
  - Counts LOCK_STRETCH.
  - locked_s=0 at any edge sends the FSM back to WAIT_LOCK (cnt cleared).
  - At terminal count with locked_s=1, moves to BUS_UP.
- BUS_UP: counts GAP_CYCLES, then moves to RUN.
- BUS_UP or RUN, re-entry to HOLD on an edge:
  - locked_s=0 → HOLD, cause←PLL_LOSS.
  - Else sw_reset_req_i=1 → HOLD, cause←SW.
  - If both are true on the same edge, PLL_LOSS wins.
- Reset outputs reassert in the cycle immediately after the sampling edge.
- reset_cause_o:
  - Updates only on those re-entry edges; otherwise holds its value.
  - Only reset_i returns it to POR.
  - Readable during the subsequent sequence and in RUN.
- cnt width is $clog2(max(HOLD_CYCLES, LOCK_STRETCH, GAP_CYCLES)+1). Counters never wrap.
- Elaboration-time assertion: any parameter <1 fails elaboration.
- Glitch-free outputs: every output is a flop.

Decomposition:
- Shared package skywave_pkg:
  - rst_state_t enum (HOLD, WAIT_LOCK, STRETCH, BUS_UP, RUN).
  - rst_cause_t enum (CAUSE_POR=2'b00, CAUSE_PLL=2'b01, CAUSE_SW=2'b10).
- One sub-module: sync_ff, a generic 2-flop synchroniser with parameter WIDTH.
  - Synchronous active-low reset to 0.
  - Reused later for the capability pins.

Test Plan:
- POR (HOLD=4, STRETCH=8, GAP=2; pll_locked_i=1 throughout; reset_i released before edge 1). Required response:
  - WAIT_LOCK at edge 4, STRETCH at edge 5.
  - bus_reset_o falls after edge 13.
  - core_reset_o falls and ready_o rises after edge 15.
  - cause=00.
- PLL glitch: drop pll_locked_i for 3 cycles mid-STRETCH → FSM returns to WAIT_LOCK; bus_reset_o never deasserts; full 8-cycle STRETCH restarts after relock.
- SW reset in RUN: sw_reset_req_i high for 10 cycles. Required response:
  - Both resets high the cycle after the sampling edge; ready_o=0.
  - HOLD persists until the request drops, then re-sequences.
  - cause=10.
- PLL loss in RUN: pll_locked_i→0. Required response:
  - Resets assert 2 edges (sync) + 1 edge later.
  - cause=01.
  - FSM waits in WAIT_LOCK indefinitely until relock.
- Simultaneous: sw_reset_req_i=1 on the same edge locked_s falls in RUN → cause=01.
- reset_i low for 1 cycle during BUS_UP (after a prior SW cause). Required response:
  - bus_reset_o=1, core_reset_o=1, cause=00 on the next cycle.
  - Full POR timeline repeats.
